// File: rtl/vae_pkg.sv
// Shared constants and types for the VAE decoder output path.
// Frame geometry is fixed by the 14x14 decoder output layer.
package vae_pkg;

  localparam int unsigned WIDTH    = 10;
  localparam int unsigned IMG_W    = 14;
  localparam int unsigned IMG_H    = 14;
  localparam int unsigned NODE_CNT = IMG_W * IMG_H;

  localparam int unsigned IDX_W = $clog2(NODE_CNT);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {ST_IDLE, ST_STREAM} stream_state_e;

endpackage

// File: rtl/vae_pixel_clamp.sv
// Signed decoder node to 8-bit unsigned pixel: arithmetic shift, then saturate to [0,255].
module vae_pixel_clamp #(
  parameter int unsigned InW   = 10,
  parameter int unsigned Shift = 0
) (
  input  logic signed [InW-1:0] node_i,
  output logic        [7:0]     pix_o
);

  logic signed [InW-1:0] v;

  assign v = node_i >>> Shift;

  // Sign bit set -> negative; any bit between sign and bit 7 set -> above 255.
  always_comb begin
    if (v[InW-1]) begin
      pix_o = 8'd0;
    end else if (|v[InW-2:8]) begin
      pix_o = 8'hff;
    end else begin
      pix_o = v[7:0];
    end
  end

endmodule

// File: rtl/vae_pixel_streamer.sv
// Captures a decoder frame on the rising edge of frame_done_i and streams it as clamped
// 8-bit pixels in raster order over valid/ready, with end-of-row and end-of-frame markers.
module vae_pixel_streamer
  import vae_pkg::*;
#(
  parameter int unsigned PixShift = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NODE_CNT-1:0][WIDTH-1:0] frame_in_i,
  input  logic                           frame_done_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [7:0]                     m_data_o,
  output logic                           m_eol_o,
  output logic                           m_last_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam idx_t LastIdx = idx_t'(NODE_CNT - 1);
  localparam col_t LastCol = col_t'(IMG_W - 1);
  localparam row_t LastRow = row_t'(IMG_H - 1);

  stream_state_e                  state_q;
  logic [NODE_CNT-1:0][WIDTH-1:0] buf_q;
  idx_t                           idx_q, idx_nxt;
  col_t                           col_q, col_nxt;
  row_t                           row_q, row_nxt;
  logic                           done_q;
  logic                           m_valid_q, m_eol_q, m_last_q, overrun_q;
  logic [7:0]                     m_data_q;
  logic [7:0]                     pix;
  logic [WIDTH-1:0]               src_node;
  logic                           start, xfer, capture;

  assign start   = frame_done_i & ~done_q;
  assign xfer    = m_valid_q & m_ready_i;
  // A new frame is accepted when idle, or exactly as the last pixel leaves.
  assign capture = start & ((state_q == ST_IDLE) | (xfer & m_last_q));

  always_comb begin
    idx_nxt = '0;
    col_nxt = '0;
    row_nxt = '0;
    if (!capture && (idx_q != LastIdx)) begin
      idx_nxt = idx_q + 1'b1;
      if (col_q == LastCol) begin
        col_nxt = '0;
        row_nxt = row_q + 1'b1;
      end else begin
        col_nxt = col_q + 1'b1;
        row_nxt = row_q;
      end
    end
  end

  // The pixel for the next output slot comes straight from the input on a capture,
  // since the buffer is only written on that same edge.
  assign src_node = capture ? frame_in_i[0] : buf_q[idx_nxt];

  vae_pixel_clamp #(
    .InW  (WIDTH),
    .Shift(PixShift)
  ) u_clamp (
    .node_i(src_node),
    .pix_o (pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_eol_q   <= 1'b0;
      m_last_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= frame_done_i;
      overrun_q <= (state_q == ST_STREAM) & start & ~capture;
      if (capture) begin
        buf_q <= frame_in_i;
      end
      if (capture || (xfer && !m_last_q)) begin
        state_q   <= ST_STREAM;
        idx_q     <= idx_nxt;
        col_q     <= col_nxt;
        row_q     <= row_nxt;
        m_valid_q <= 1'b1;
        m_data_q  <= pix;
        m_eol_q   <= (col_nxt == LastCol);
        m_last_q  <= (col_nxt == LastCol) && (row_nxt == LastRow);
      end else if (xfer) begin
        state_q   <= ST_IDLE;
        idx_q     <= '0;
        col_q     <= '0;
        row_q     <= '0;
        m_valid_q <= 1'b0;
        m_data_q  <= '0;
        m_eol_q   <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_eol_o   = m_eol_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q == ST_STREAM);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_vae_pixel_streamer.sv
// Self-checking bench for vae_pixel_streamer: ramp, clamp table, backpressure,
// held start level, overrun/back-to-back frames and mid-stream reset.
module tb_vae_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, frame_done, m_ready;
  logic [195:0][9:0] frame_in;
  logic              m_valid, m_eol, m_last, busy, overrun;
  logic [7:0]        m_data;
  logic              v1, e1, l1, b1, o1;
  logic [7:0]        d1;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt  = 0;
  int q0[$];
  int q1[$];
  logic prev_stall = 1'b0;
  logic prev_ov    = 1'b0;
  int   prev_rec   = 0;

  logic [195:0][9:0] fa, fb;

  typedef struct {
    logic [9:0] node;
    int         exp0;
    int         exp1;
  } clamp_vec_t;
  clamp_vec_t tv[8];

  vae_pixel_streamer #(.PixShift(0)) dut (
    .clk(clk), .rst(rst), .frame_in_i(frame_in), .frame_done_i(frame_done),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_eol_o(m_eol),
    .m_last_o(m_last), .busy_o(busy), .overrun_o(overrun)
  );

  vae_pixel_streamer #(.PixShift(1)) dut1 (
    .clk(clk), .rst(rst), .frame_in_i(frame_in), .frame_done_i(frame_done),
    .m_valid_o(v1), .m_ready_i(1'b1), .m_data_o(d1), .m_eol_o(e1),
    .m_last_o(l1), .busy_o(b1), .overrun_o(o1)
  );

  // Reference: pixel from the node value by plain integer arithmetic.
  function automatic int ref_pix(logic [9:0] node, int sh);
    int v;
    v = int'($signed(node)) >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_rec(int i, logic [9:0] node, int sh);
    return ((i % 14 == 13) ? 512 : 0) + ((i == 195) ? 256 : 0) + ref_pix(node, sh);
  endfunction

  function automatic int rec_of(logic [7:0] d, logic e, logic l);
    return (int'(e) << 9) | (int'(l) << 8) | int'(d);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int qget(int sel, int i);
    if (sel == 0) return (i < q0.size()) ? q0[i] : -1;
    return (i < q1.size()) ? q1[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_q0(int n, int limit, string name);
    int k;
    k = 0;
    while (q0.size() < n && k < limit) begin
      tick();
      k++;
    end
    if (q0.size() < n) chk(name, q0.size(), n);
  endtask

  task automatic check_seq(int sel, int base, logic [195:0][9:0] f, int sh, string name);
    for (int i = 0; i < 196; i++) chk(name, qget(sel, base + i), ref_rec(i, f[i], sh));
  endtask

  task automatic rand_frame(output logic [195:0][9:0] f);
    for (int i = 0; i < 196; i++) f[i] = 10'($urandom_range(0, 1023));
  endtask

  // Transfer recorder plus stall-hold, marker-qualification and pulse-width checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_hold", rec_of(m_data, m_eol, m_last), prev_rec);
      end
      if (!m_valid) chk("idle_markers", int'({m_eol, m_last}), 0);
      if (prev_ov) chk("overrun_pulse", int'(overrun), 0);
      if (overrun) ov_cnt++;
      if (m_valid && m_ready) q0.push_back(rec_of(m_data, m_eol, m_last));
      if (v1) q1.push_back(rec_of(d1, e1, l1));
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_ov    = !rst && overrun;
    prev_rec   = rec_of(m_data, m_eol, m_last);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    frame_done = 1'b0;
    m_ready = 1'b0;
    frame_in = '0;
    tv[0] = '{10'h200, 0, 0};
    tv[1] = '{10'h3FF, 0, 0};
    tv[2] = '{10'h000, 0, 0};
    tv[3] = '{10'h0FF, 255, 127};
    tv[4] = '{10'h100, 255, 128};
    tv[5] = '{10'h1FF, 255, 255};
    tv[6] = '{10'h1FE, 255, 255};
    tv[7] = '{10'h12C, 255, 150};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({m_valid, m_data, m_eol, m_last, busy, overrun}), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: ramp, latency 1, consecutive pixels
    for (int i = 0; i < 196; i++) fa[i] = 10'(i);
    frame_in = fa;
    m_ready = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    chk("t1_valid_before_edge", int'(m_valid), 0);
    @(posedge clk);
    #1 frame_done = 1'b0;
    for (int i = 0; i < 196; i++) begin
      @(negedge clk);
      chk("t1_valid", int'(m_valid), 1);
      chk("t1_pixel", rec_of(m_data, m_eol, m_last), ref_rec(i, fa[i], 0));
    end
    @(negedge clk);
    chk("t1_idle_after", int'({m_valid, busy}), 0);
    repeat (3) tick();

    // 2: clamp table in the first nodes, random remainder, both shifts
    rand_frame(fa);
    for (int i = 0; i < 8; i++) fa[i] = tv[i].node;
    frame_in = fa;
    q0.delete();
    q1.delete();
    pulse_done();
    wait_q0(196, 400, "t2_timeout");
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      chk("t2_clamp_shift0", qget(0, i) & 255, tv[i].exp0);
      chk("t2_clamp_shift1", qget(1, i) & 255, tv[i].exp1);
    end
    check_seq(0, 0, fa, 0, "t2_seq_shift0");
    check_seq(1, 0, fa, 1, "t2_seq_shift1");

    // 3: random backpressure, ~30% ready
    rand_frame(fa);
    frame_in = fa;
    q0.delete();
    pulse_done();
    k = 0;
    while (q0.size() < 196 && k < 5000) begin
      m_ready = ($urandom_range(0, 99) < 30);
      tick();
      k++;
    end
    m_ready = 1'b1;
    repeat (5) tick();
    chk("t3_count", q0.size(), 196);
    check_seq(0, 0, fa, 0, "t3_seq");

    // 4: frame_done held high -> one frame only
    rand_frame(fa);
    frame_in = fa;
    q0.delete();
    ov_cnt = 0;
    frame_done = 1'b1;
    repeat (500) tick();
    frame_done = 1'b0;
    repeat (5) tick();
    chk("t4_count", q0.size(), 196);
    chk("t4_overrun", ov_cnt, 0);
    check_seq(0, 0, fa, 0, "t4_seq");

    // 5a: second edge at pixel 50 is dropped
    rand_frame(fa);
    rand_frame(fb);
    frame_in = fa;
    q0.delete();
    ov_cnt = 0;
    pulse_done();
    wait_q0(50, 400, "t5a_reach50");
    frame_in = fb;
    pulse_done();
    chk("t5a_overrun_on", int'(overrun), 1);
    chk("t5a_busy", int'(busy), 1);
    wait_q0(196, 400, "t5a_timeout");
    repeat (5) tick();
    chk("t5a_count", q0.size(), 196);
    chk("t5a_overrun_cnt", ov_cnt, 1);
    check_seq(0, 0, fa, 0, "t5a_seq");

    // 5b: edge coincident with the final transfer -> back-to-back frame
    rand_frame(fa);
    rand_frame(fb);
    frame_in = fa;
    q0.delete();
    ov_cnt = 0;
    pulse_done();
    wait_q0(195, 400, "t5b_reach195");
    frame_in = fb;
    pulse_done();
    chk("t5b_valid", int'(m_valid), 1);
    chk("t5b_first_pix", rec_of(m_data, m_eol, m_last), ref_rec(0, fb[0], 0));
    chk("t5b_no_overrun", int'(overrun), 0);
    wait_q0(392, 600, "t5b_timeout");
    repeat (5) tick();
    chk("t5b_count", q0.size(), 392);
    chk("t5b_overrun_cnt", ov_cnt, 0);
    check_seq(0, 0, fa, 0, "t5b_seq_a");
    check_seq(0, 196, fb, 0, "t5b_seq_b");

    // 6: asynchronous reset mid-stream, then a fresh frame from pixel 0
    rand_frame(fa);
    rand_frame(fb);
    frame_in = fa;
    q0.delete();
    pulse_done();
    wait_q0(100, 400, "t6_reach100");
    rst = 1'b1;
    #1;
    chk("t6_async_reset", int'({m_valid, m_data, m_eol, m_last, busy, overrun}), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_idle_after_reset", int'({m_valid, busy}), 0);
    frame_in = fb;
    q0.delete();
    pulse_done();
    wait_q0(196, 400, "t6_timeout");
    repeat (5) tick();
    chk("t6_count", q0.size(), 196);
    check_seq(0, 0, fb, 0, "t6_seq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
